// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter.
// Register-file geometry and the writeback request bundle.
package wb_pkg;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NUM_REGS = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] onehot(
    input logic [AW-1:0] a
  );
    logic [NUM_REGS-1:0] r;
    r = '0;
    r[a] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: primary/secondary producers and regfile port.
// master drives requests, slave is the arbiter.
interface regfile_wb_arbiter_if
  import wb_pkg::*;
();

  logic                pri_valid;
  logic [AW-1:0]       pri_waddr;
  logic [DW-1:0]       pri_wdata;
  logic                sec_valid;
  logic                sec_ready;
  logic [AW-1:0]       sec_waddr;
  logic [DW-1:0]       sec_wdata;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [DW-1:0]       wdata;
  logic [NUM_REGS-1:0] pending;

  modport master (
    output pri_valid, pri_waddr, pri_wdata,
    output sec_valid, sec_waddr, sec_wdata,
    input  sec_ready,
    input  we, waddr, wdata, pending
  );

  modport slave (
    input  pri_valid, pri_waddr, pri_wdata,
    input  sec_valid, sec_waddr, sec_wdata,
    output sec_ready,
    output we, waddr, wdata, pending
  );

endinterface

// File: rtl/regfile_wb_arbiter_sec_fifo.sv
// Secondary writeback FIFO with per-entry live bits.
// Younger primary writes kill matching queued entries.
module wb_sec_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [AW-1:0]       push_addr,
  input  logic [DW-1:0]       push_data,
  input  logic                pop,
  input  logic                squash_en,
  input  logic [AW-1:0]       squash_addr,
  output logic                full,
  output logic                empty,
  output wb_req_t             head,
  output logic [NUM_REGS-1:0] pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head.valid = live_q[rd_ptr];
  assign head.addr  = addr_q[rd_ptr];
  assign head.data  = data_q[rd_ptr];

  // entry payload; no reset needed, gated by live bits
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  // live bits: squash stored matches, clear on pop, set on push
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_en && addr_q[i] == squash_addr)
          live_q[i] <= 1'b0;
      end
      if (pop_ok)
        live_q[rd_ptr] <= 1'b0;
      if (push_ok)
        live_q[wr_ptr] <= 1'b1;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop_ok)
        count <= count + CW'(1);
      else if (pop_ok && !push_ok)
        count <= count - CW'(1);
    end
  end

  // pending mask: union of live entry destinations
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i])
        pending = pending | onehot(addr_q[i]);
    end
    pending[0] = 1'b0;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter driving the regfile write port.
// Optional forwarding ports under REGFILE_WB_FWD_EN.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave bus
`ifdef REGFILE_WB_FWD_EN
  ,
  input  logic [AW-1:0]       fwd_raddr1,
  input  logic [AW-1:0]       fwd_raddr2,
  output logic                fwd_hit1,
  output logic                fwd_hit2,
  output logic [DW-1:0]       fwd_data1,
  output logic [DW-1:0]       fwd_data2
`endif
);

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          squash_en;
  wb_req_t       head;
  wb_req_t       sel;
  logic          upd;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;

  assign bus.sec_ready = !full;
  assign push = bus.sec_valid && !full
             && bus.sec_waddr != REG_ZERO;
  assign pop  = !bus.pri_valid && !empty;
  assign squash_en = bus.pri_valid
                  && bus.pri_waddr != REG_ZERO;

  wb_sec_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (bus.sec_waddr),
    .push_data   (bus.sec_wdata),
    .pop         (pop),
    .squash_en   (squash_en),
    .squash_addr (bus.pri_waddr),
    .full        (full),
    .empty       (empty),
    .head        (head),
    .pending     (bus.pending)
  );

  // select primary first, else a live FIFO head
  always_comb begin
    sel = '0;
    upd = 1'b0;
    if (bus.pri_valid) begin
      sel.valid = 1'b1;
      sel.addr  = bus.pri_waddr;
      sel.data  = bus.pri_wdata;
      upd = 1'b1;
    end else if (!empty && head.valid) begin
      sel = head;
      upd = 1'b1;
    end
  end

  // registered regfile write port; r0 never written
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= upd && sel.addr != REG_ZERO;
      if (upd) begin
        waddr_q <= sel.addr;
        wdata_q <= sel.data;
      end
    end
  end

  assign bus.we    = we_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;

`ifdef REGFILE_WB_FWD_EN
  assign fwd_hit1  = we_q && waddr_q == fwd_raddr1
                  && fwd_raddr1 != REG_ZERO;
  assign fwd_hit2  = we_q && waddr_q == fwd_raddr2
                  && fwd_raddr2 != REG_ZERO;
  assign fwd_data1 = wdata_q;
  assign fwd_data2 = wdata_q;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback stage directly upstream of the 32x32 register file; drives its single write port (we/waddr/wdata).
- Merges two producers. Primary (pipeline ALU/load result) has no backpressure and top priority. Secondary (multi-cycle unit, e.g. mul/div) uses a valid/ready handshake and is buffered in a small FIFO.
- Exports a pending-write mask for the hazard/stall logic.

Parameters:
- DEPTH, 2, secondary FIFO entries; power of 2, >=2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- pri_valid  in  1  primary write request
- pri_waddr  in  AW  primary destination register
- pri_wdata  in  DW  primary write data
- sec_valid  in  1  secondary write request
- sec_ready  out  1  secondary accept; transfer occurs when sec_valid&&sec_ready
- sec_waddr  in  AW  secondary destination register
- sec_wdata  in  DW  secondary write data
- we  out  1  to regfile write enable (registered)
- waddr  out  AW  to regfile write address (registered)
- wdata  out  DW  to regfile write data (registered)
- pending  out  32  bit i = live queued secondary write to reg i

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high, sampled on the clk rising edge.
- Reset values: we=0, waddr=0, wdata=0. FIFO empty: rd/wr ptr=0, count=0, all entry-valid bits 0. Hence sec_ready=1 and pending=0.
- Reset mid-operation: all queued entries are discarded. No regfile write is issued in the reset cycle or the cycle after.
- Latency: a selected request appears on we/waddr/wdata one cycle after selection. The regfile commits it on the following edge.
- Arbitration, each cycle:
  - If pri_valid: output the primary request.
  - Else if the FIFO is non-empty: pop the head. A live head is output. A squashed head is popped with we=0, which consumes the cycle.
  - Else: we=0. waddr/wdata hold their previous values.
- Register 0: any selected write with addr 0 drives we=0.
- Secondary enqueue rules:
  - A secondary handshake with sec_waddr=0 completes but nothing is stored.
  - sec_ready = !full, derived from registered count only. There is no combinational path from sec_valid or pri_valid.
  - Push when full is impossible by construction.
  - Push and pop in the same cycle: both occur, and count is unchanged.
- Squash (ordering rule): the primary is program-order younger than any already-queued secondary result.
  - When pri_valid with pri_waddr!=0, every stored live entry with a matching address is marked dead in that cycle.
  - An entry being pushed in the same cycle is NOT squashed; it is treated as younger.
- Pending mask: OR over live entries of the one-hot of their address. Combinational from FIFO state. Bit 0 is always 0.
- Pointers: wrap modulo DEPTH. Count is AW-independent, width clog2(DEPTH)+1. Full is count==DEPTH; empty is count==0.
- Starvation: a continuous pri_valid stream starves the FIFO. The pipeline guarantees bubbles; the block does not time out.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- Defined: adds forwarding ports.
  - Inputs fwd_raddr1 and fwd_raddr2 (AW each).
  - Outputs fwd_hit1/fwd_hit2 (1) and fwd_data1/fwd_data2 (DW).
  - fwd_hitN = we && waddr==fwd_raddrN && fwd_raddrN!=0. fwd_dataN = wdata. Both combinational.
  - Purpose: lets the decode stage see the value the regfile commits at the next edge.
- Undefined: these ports and their logic are absent. Core behaviour is identical.

Decomposition:
- Package wb_pkg: AW, DW, NUM_REGS=32, REG_ZERO=0, and typedef wb_req_t {valid, addr, data}.
- One natural sub-module: wb_sec_fifo.
  - Storage, pointers and count.
  - Per-entry live bit and squash-compare port.
  - Produces the pending mask.
- The top level holds the arbiter and output registers.

Test Plan:
- Reset:
  - Stimulus: assert rst for 2 cycles while pri_valid=1, addr=3.
  - Expected: we=0 through the cycle after rst deasserts; sec_ready=1; pending=0.
- Primary priority:
  - Stimulus: pri (5, 0xAAAA0000) and sec (6, 0x1234) in the same cycle.
  - Expected: next cycle we=1, waddr=5, wdata=0xAAAA0000. The cycle after: waddr=6, wdata=0x1234. pending[6] is set for exactly one cycle.
- Full/backpressure:
  - Stimulus: pri_valid=1 constantly; push 2 secondary writes (DEPTH=2).
  - Expected: sec_ready=0 while full. After pri_valid drops, both drain in order on consecutive cycles, then sec_ready=1.
- Squash:
  - Stimulus: queue sec (7, 0x11), then pri (7, 0x22).
  - Expected: regfile sees only 0x22 to r7. The dead entry pops with we=0. pending[7] clears on the squash edge.
- r0 handling:
  - Stimulus: pri (0, 0xFFFF) and sec (0, 0xFFFF).
  - Expected: we stays 0; the sec handshake completes; pending=0.
- REGFILE_WB_FWD_EN:
  - Stimulus: while we=1, waddr=9, wdata=0xDEAD, drive fwd_raddr1=9 and fwd_raddr2=0.
  - Expected: fwd_hit1=1, fwd_data1=0xDEAD; fwd_hit2=0.
